// File: rtl/stage_sequencer.sv
// stage_sequencer
//   Multi-cycle phase sequencer for the 8-bit RISC core. It walks each instruction
//   through fetch, decode, execute, memory and writeback and drives one-hot phase
//   enables into the datapath. It provides:
//     - run and single-step control;
//     - a memory-ready handshake with timeout;
//     - halt handling;
//     - a retired-instruction counter.
//
//   Ports
//     clk        in   system clock, rising edge
//     rst        in   asynchronous active-low reset
//     run        in   level, free-running execution
//     step       in   one-cycle pulse, run one instruction from IDLE while run=0
//     ir_halt    in   decoded HALT opcode, sampled in ID
//     ir_mem     in   instruction uses data memory, sampled in ID
//     ir_wb      in   instruction writes the register file, sampled in ID
//     mem_ready  in   memory handshake, sampled in IF and MEM only
//     clr_err    in   leaves ERR
//     en_if/en_id/en_ex/en_mem/en_wb
//                out  one-hot phase enables
//     mem_req    out  high in IF and MEM
//     busy       out  high in IF, ID, EX, MEM and WB
//     halted     out  high in HALT
//     err        out  high in ERR
//     instr_cnt  out  retired-instruction count, wraps
//     state      out  state code for debug
//
//   state | meaning
//   ------+--------------------------------------------------------
//   IDLE  | waiting for run or a step pulse
//   IF    | instruction fetch, waits for mem_ready
//   ID    | decode, latches the instruction class flags
//   EX    | execute
//   MEM   | data memory access, waits for mem_ready
//   WB    | register file writeback
//   HALT  | HALT opcode decoded, only reset leaves
//   ERR   | memory did not answer in time, clr_err leaves
`timescale 1ns/1ps

module stage_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             ir_halt,
    input  logic             ir_mem,
    input  logic             ir_wb,
    input  logic             mem_ready,
    input  logic             clr_err,
    output logic             en_if,
    output logic             en_id,
    output logic             en_ex,
    output logic             en_mem,
    output logic             en_wb,
    output logic             mem_req,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [2:0]       state
);

    // The wait timer counts down the remaining tolerated not-ready cycles.
    // It is reloaded on every state change, so it counts consecutive stalls only.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6,
        S_ERR  = 3'd7
    } state_t;

    state_t            cur_state;
    state_t            nxt_state;
    logic [WAIT_W-1:0] wait_left;
    logic              wait_done;
    logic              step_mode;
    logic              flag_mem;
    logic              flag_wb;
    logic              eoi;

    always_comb begin
        nxt_state = cur_state;
        eoi       = 1'b0;
        wait_done = (wait_left == '0);
        case (cur_state)
            S_IDLE: if (run || step) nxt_state = S_IF;
            S_IF: begin
                if (mem_ready)      nxt_state = S_ID;
                else if (wait_done) nxt_state = S_ERR;
            end
            S_ID:   nxt_state = ir_halt ? S_HALT : S_EX;
            S_EX: begin
                if (flag_mem)     nxt_state = S_MEM;
                else if (flag_wb) nxt_state = S_WB;
                else              eoi = 1'b1;
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (flag_wb) nxt_state = S_WB;
                    else         eoi = 1'b1;
                end else if (wait_done) begin
                    nxt_state = S_ERR;
                end
            end
            S_WB:   eoi = 1'b1;
            S_HALT: nxt_state = S_HALT;
            S_ERR:  if (clr_err) nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
        // A single-stepped instruction always returns to IDLE.
        if (eoi) nxt_state = (run && !step_mode) ? S_IF : S_IDLE;
    end

    // Outputs are registered from the next state, so they equal a Moore decode
    // of the state register without any combinational path to the pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= S_IDLE;
            wait_left <= '0;
            step_mode <= 1'b0;
            flag_mem  <= 1'b0;
            flag_wb   <= 1'b0;
            instr_cnt <= '0;
            en_if     <= 1'b0;
            en_id     <= 1'b0;
            en_ex     <= 1'b0;
            en_mem    <= 1'b0;
            en_wb     <= 1'b0;
            mem_req   <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            err       <= 1'b0;
            state     <= 3'd0;
        end else begin
            cur_state <= nxt_state;

            // wait_left cannot underflow: at zero a further stall leaves for ERR,
            // which reloads it.
            if (nxt_state != cur_state) begin
                wait_left <= WAIT_LOAD;
            end else if ((cur_state == S_IF || cur_state == S_MEM) && !mem_ready) begin
                wait_left <= wait_left - WAIT_W'(1);
            end

            if (cur_state == S_IDLE && nxt_state == S_IF) begin
                step_mode <= ~run;
            end else if (eoi) begin
                step_mode <= 1'b0;
            end

            if (cur_state == S_ID) begin
                flag_mem <= ir_mem;
                flag_wb  <= ir_wb;
            end

            if (eoi) instr_cnt <= instr_cnt + CNT_W'(1);

            en_if   <= (nxt_state == S_IF);
            en_id   <= (nxt_state == S_ID);
            en_ex   <= (nxt_state == S_EX);
            en_mem  <= (nxt_state == S_MEM);
            en_wb   <= (nxt_state == S_WB);
            mem_req <= (nxt_state == S_IF) || (nxt_state == S_MEM);
            busy    <= (nxt_state == S_IF) || (nxt_state == S_ID) || (nxt_state == S_EX) ||
                       (nxt_state == S_MEM) || (nxt_state == S_WB);
            halted  <= (nxt_state == S_HALT);
            err     <= (nxt_state == S_ERR);
            state   <= nxt_state;
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
`timescale 1ns/1ps

module tb_stage_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, run, step, ir_halt, ir_mem, ir_wb, mem_ready, clr_err;

    logic        en_if, en_id, en_ex, en_mem, en_wb, mem_req, busy, halted, err;
    logic [15:0] instr_cnt;
    logic [2:0]  state;

    logic        en_if_4, en_id_4, en_ex_4, en_mem_4, en_wb_4, mem_req_4, busy_4, halted_4, err_4;
    logic [3:0]  instr_cnt_4;
    logic [2:0]  state_4;

    stage_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .ir_halt(ir_halt), .ir_mem(ir_mem),
        .ir_wb(ir_wb), .mem_ready(mem_ready), .clr_err(clr_err),
        .en_if(en_if), .en_id(en_id), .en_ex(en_ex), .en_mem(en_mem), .en_wb(en_wb),
        .mem_req(mem_req), .busy(busy), .halted(halted), .err(err),
        .instr_cnt(instr_cnt), .state(state)
    );

    stage_sequencer #(.CNT_W(4)) dut_w4 (
        .clk(clk), .rst(rst), .run(run), .step(step), .ir_halt(ir_halt), .ir_mem(ir_mem),
        .ir_wb(ir_wb), .mem_ready(mem_ready), .clr_err(clr_err),
        .en_if(en_if_4), .en_id(en_id_4), .en_ex(en_ex_4), .en_mem(en_mem_4), .en_wb(en_wb_4),
        .mem_req(mem_req_4), .busy(busy_4), .halted(halted_4), .err(err_4),
        .instr_cnt(instr_cnt_4), .state(state_4)
    );

    // One entry per clock cycle: the expected state during that cycle, the
    // expected count, and the inputs the bench drives during that cycle.
    typedef struct packed {
        logic [2:0]  st;
        logic        rdy;
        logic        rn;
        logic        stp;
        logic        clr;
        logic        m;
        logic        w;
        logic        h;
        logic [15:0] cnt;
    } ent_t;

    ent_t        exp_q[$];
    logic [43:0] obs_q[$];
    int          exp_cnt;
    int          n_pass;
    int          n_total;

    localparam logic [2:0] IDLE = 3'd0, IF_ = 3'd1, ID = 3'd2, EX = 3'd3,
                           MEM = 3'd4, WB = 3'd5, HALT = 3'd6, ERR = 3'd7;

    // {en_if, en_id, en_ex, en_mem, en_wb, mem_req, busy, halted, err}
    function automatic logic [8:0] exp_outs(input logic [2:0] s);
        case (s)
            IF_:     return 9'b100001100;
            ID:      return 9'b010000100;
            EX:      return 9'b001000100;
            MEM:     return 9'b000101100;
            WB:      return 9'b000010100;
            HALT:    return 9'b000000010;
            ERR:     return 9'b000000001;
            default: return 9'b000000000;
        endcase
    endfunction

    function automatic logic [43:0] obs_vec();
        return {state, en_if, en_id, en_ex, en_mem, en_wb, mem_req, busy, halted, err, instr_cnt,
                state_4, en_if_4, en_id_4, en_ex_4, en_mem_4, en_wb_4, mem_req_4, busy_4,
                halted_4, err_4, instr_cnt_4};
    endfunction

    function automatic logic [43:0] exp_vec(input ent_t e);
        logic [15:0] c;
        c = e.cnt;
        return {e.st, exp_outs(e.st), c, e.st, exp_outs(e.st), c[3:0]};
    endfunction

    // Inputs that the state should ignore are randomised.
    function automatic void push(input logic [2:0] st, input logic rdy, input logic rn,
                                 input logic stp, input logic clr, input logic m,
                                 input logic w, input logic h);
        ent_t e;
        e.st  = st;
        e.rn  = rn;
        e.rdy = (st == IF_ || st == MEM) ? rdy : 1'($urandom);
        e.stp = (st == IDLE) ? stp : 1'($urandom);
        e.clr = (st == ERR) ? clr : 1'($urandom);
        if (st == ID) {e.m, e.w, e.h} = {m, w, h};
        else          {e.m, e.w, e.h} = 3'($urandom);
        e.cnt = exp_cnt[15:0];
        exp_q.push_back(e);
    endfunction

    // run_mode: 0 = run low, 1 = run high, 2 = random each cycle
    function automatic void add_instr(input logic m, input logic w, input int si,
                                      input int sm, input int run_mode);
        logic r;
        for (int s = 0; s <= si; s++) begin
            r = (run_mode == 2) ? 1'($urandom) : (run_mode == 1);
            push(IF_, (s == si), r, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        r = (run_mode == 2) ? 1'($urandom) : (run_mode == 1);
        push(ID, 1'b0, r, 1'b0, 1'b0, m, w, 1'b0);
        r = (run_mode == 2) ? 1'($urandom) : (run_mode == 1);
        push(EX, 1'b0, r, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (m) begin
            for (int s = 0; s <= sm; s++) begin
                r = (run_mode == 2) ? 1'($urandom) : (run_mode == 1);
                push(MEM, (s == sm), r, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
        if (w) begin
            r = (run_mode == 2) ? 1'($urandom) : (run_mode == 1);
            push(WB, 1'b0, r, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        exp_cnt++;
    endfunction

    function automatic void set_run(input int idx, input logic v);
        ent_t t;
        t = exp_q[idx];
        t.rn = v;
        exp_q[idx] = t;
    endfunction

    function automatic void set_step(input int idx, input logic v);
        ent_t t;
        t = exp_q[idx];
        t.stp = v;
        exp_q[idx] = t;
    endfunction

    function automatic int rnd_stall();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : 0;
    endfunction

    task automatic play();
        obs_q.delete();
        foreach (exp_q[i]) begin
            @(negedge clk);
            obs_q.push_back(obs_vec());
            run       = exp_q[i].rn;
            step      = exp_q[i].stp;
            clr_err   = exp_q[i].clr;
            mem_ready = exp_q[i].rdy;
            ir_mem    = exp_q[i].m;
            ir_wb     = exp_q[i].w;
            ir_halt   = exp_q[i].h;
        end
    endtask

    task automatic quiet_inputs();
        run = 1'b0; step = 1'b0; clr_err = 1'b0; mem_ready = 1'b0;
        ir_mem = 1'b0; ir_wb = 1'b0; ir_halt = 1'b0;
    endtask

    task automatic test_reset();
        quiet_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if (obs_vec() !== 44'd0) $display("FAIL reset: got %h want 0", obs_vec());
        else n_pass++;
        rst = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_run_wb();
        exp_q.delete();
        push(IDLE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) add_instr(1'b0, 1'b1, 0, 0, 1);
        set_run(exp_q.size() - 1, 1'b0);
        push(IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        play();
        foreach (exp_q[i]) begin
            n_total++;
            if (obs_q[i] !== exp_vec(exp_q[i]))
                $display("FAIL run_wb[%0d]: got %h want %h", i, obs_q[i], exp_vec(exp_q[i]));
            else n_pass++;
        end
    endtask

    task automatic test_step();
        exp_q.delete();
        push(IDLE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add_instr(1'b1, 1'b1, 0, 0, 0);
        set_step(exp_q.size() - 3, 1'b1);
        for (int k = 0; k < 3; k++) push(IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(IDLE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add_instr(1'b0, 1'b0, 2, 0, 1);
        push(IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        play();
        foreach (exp_q[i]) begin
            n_total++;
            if (obs_q[i] !== exp_vec(exp_q[i]))
                $display("FAIL step[%0d]: got %h want %h", i, obs_q[i], exp_vec(exp_q[i]));
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        exp_q.delete();
        push(IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_instr(1'b1, 1'b0, 0, 3, 0);
        push(IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_instr(1'b1, 1'b1, 0, 14, 0);
        push(IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_instr(1'b0, 1'b0, 14, 0, 0);
        push(IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(IF_, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(ID, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push(EX, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 15; k++) push(MEM, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(ERR, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push(ERR, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(ERR, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push(IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 15; k++) push(IF_, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(ERR, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push(IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        play();
        foreach (exp_q[i]) begin
            n_total++;
            if (obs_q[i] !== exp_vec(exp_q[i]))
                $display("FAIL timeout[%0d]: got %h want %h", i, obs_q[i], exp_vec(exp_q[i]));
            else n_pass++;
        end
    endtask

    task automatic test_run_drop();
        exp_q.delete();
        push(IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_instr(1'b0, 1'b0, 0, 0, 1);
        add_instr(1'b0, 1'b1, 0, 0, 1);
        set_run(exp_q.size() - 2, 1'b0);
        set_run(exp_q.size() - 1, 1'b0);
        push(IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        play();
        foreach (exp_q[i]) begin
            n_total++;
            if (obs_q[i] !== exp_vec(exp_q[i]))
                $display("FAIL run_drop[%0d]: got %h want %h", i, obs_q[i], exp_vec(exp_q[i]));
            else n_pass++;
        end
    endtask

    task automatic test_halt();
        exp_q.delete();
        push(IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(IF_, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(ID, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) push(HALT, 1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        play();
        foreach (exp_q[i]) begin
            n_total++;
            if (obs_q[i] !== exp_vec(exp_q[i]))
                $display("FAIL halt[%0d]: got %h want %h", i, obs_q[i], exp_vec(exp_q[i]));
            else n_pass++;
        end
        #2;
        quiet_inputs();
        rst = 1'b0;
        #1;
        n_total++;
        if (obs_vec() !== 44'd0) $display("FAIL halt_reset: got %h want 0", obs_vec());
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_reset_mid_mem();
        exp_q.delete();
        push(IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_instr(1'b0, 1'b1, 0, 0, 1);
        push(IF_, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(ID, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        push(EX, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) push(MEM, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        play();
        foreach (exp_q[i]) begin
            n_total++;
            if (obs_q[i] !== exp_vec(exp_q[i]))
                $display("FAIL mem_wait[%0d]: got %h want %h", i, obs_q[i], exp_vec(exp_q[i]));
            else n_pass++;
        end
        #2;
        quiet_inputs();
        rst = 1'b0;
        #1;
        n_total++;
        if (obs_vec() !== 44'd0) $display("FAIL mem_reset: got %h want 0", obs_vec());
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_random_wrap();
        exp_q.delete();
        push(IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++)
            add_instr(1'($urandom), 1'($urandom), rnd_stall(), rnd_stall(), 1);
        set_run(exp_q.size() - 1, 1'b0);
        push(IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        play();
        foreach (exp_q[i]) begin
            n_total++;
            if (obs_q[i] !== exp_vec(exp_q[i]))
                $display("FAIL random_run[%0d]: got %h want %h", i, obs_q[i], exp_vec(exp_q[i]));
            else n_pass++;
        end
        n_total++;
        if (instr_cnt_4 !== 4'd0 || instr_cnt !== 16'd16)
            $display("FAIL wrap: got cnt=%0d cnt4=%0d want cnt=16 cnt4=0", instr_cnt, instr_cnt_4);
        else n_pass++;

        // Single instructions started by run or by step. In step mode run may
        // toggle freely; the instruction must still return to IDLE.
        exp_q.delete();
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                push(IDLE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                add_instr(1'($urandom), 1'($urandom), rnd_stall(), rnd_stall(), 2);
            end else begin
                push(IDLE, 1'b0, 1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
                add_instr(1'($urandom), 1'($urandom), rnd_stall(), rnd_stall(), 2);
                set_run(exp_q.size() - 1, 1'b0);
            end
            push(IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        play();
        foreach (exp_q[i]) begin
            n_total++;
            if (obs_q[i] !== exp_vec(exp_q[i]))
                $display("FAIL random_single[%0d]: got %h want %h", i, obs_q[i], exp_vec(exp_q[i]));
            else n_pass++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        exp_cnt = 0;
        test_reset();
        test_run_wb();
        test_step();
        test_timeout();
        test_run_drop();
        test_halt();
        test_reset_mid_mem();
        test_random_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
